sprite_renderer: RTL and testbench

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_renderer.sv | 131 +++++++++++++
 tb/tb_sprite_renderer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite renderer shared types and constants (row length follows SPRITE_MIRROR_EN)
package sprite_pkg;

    typedef enum logic [2:0] {
        WAIT_VSTART = 3'd0,
        WAIT_LOAD   = 3'd1,
        LOAD_SETUP  = 3'd2,
        LOAD_FETCH  = 3'd3,
        WAIT_HSTART = 3'd4,
        DRAW        = 3'd5
    } state_t;

    localparam int SPR_ROWS_DEF   = 16;
    localparam int ROW_BITS_DEF   = 8;
    // A mirrored row shows the ROM word followed by its reflection.
    localparam int MIRROR_ROW_LEN = 2 * ROW_BITS_DEF;
    localparam int PLAIN_ROW_LEN  = ROW_BITS_DEF;

endpackage

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - scanline sprite renderer; SPRITE_MIRROR_EN selects 16-pixel mirrored rows
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_ROWS = SPR_ROWS_DEF,
    parameter int ROW_BITS = ROW_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vstart,
    input  logic                load,
    input  logic                hstart,
    output logic [3:0]          rom_addr,
    input  logic [ROW_BITS-1:0] rom_bits,
    output logic                gfx,
    output logic                in_progress
);

    localparam int IDX_W = $clog2(ROW_BITS);
    localparam int XW    = IDX_W + 1;
`ifdef SPRITE_MIRROR_EN
    localparam int ROW_LEN = MIRROR_ROW_LEN;
`else
    localparam int ROW_LEN = PLAIN_ROW_LEN;
`endif
    localparam logic [XW-1:0] X_LAST = XW'(ROW_LEN - 1);
    localparam logic [3:0]    Y_LAST = 4'(SPR_ROWS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          ycount;
    logic [XW-1:0]       xcount;
    logic [ROW_BITS-1:0] rowbuf;
    logic [IDX_W-1:0]    bit_idx;
    logic                y_clr;
    logic                y_inc;
    logic                x_clr;
    logic                x_inc;
    logic                row_ld;

    // State register; reset parks the renderer until the next vstart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_VSTART;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls; vstart resynchronises from any state.
    always_comb begin
        state_nxt = state;
        y_clr     = 1'b0;
        y_inc     = 1'b0;
        x_clr     = 1'b0;
        x_inc     = 1'b0;
        row_ld    = 1'b0;
        if (vstart) begin
            state_nxt = WAIT_LOAD;
            y_clr     = 1'b1;
        end else begin
            case (state)
                WAIT_VSTART: state_nxt = WAIT_VSTART;
                WAIT_LOAD: begin
                    if (load) state_nxt = LOAD_SETUP;
                end
                LOAD_SETUP: state_nxt = LOAD_FETCH;
                LOAD_FETCH: begin
                    row_ld    = 1'b1;
                    state_nxt = WAIT_HSTART;
                end
                WAIT_HSTART: begin
                    if (hstart) begin
                        state_nxt = DRAW;
                        x_clr     = 1'b1;
                    end
                end
                DRAW: begin
                    if (xcount == X_LAST) begin
                        if (ycount == Y_LAST) begin
                            state_nxt = WAIT_VSTART;
                        end else begin
                            y_inc     = 1'b1;
                            state_nxt = WAIT_LOAD;
                        end
                    end else begin
                        x_inc = 1'b1;
                    end
                end
                default: state_nxt = WAIT_VSTART;
            endcase
        end
    end

    // Row/column counters and the latched ROM row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ycount <= '0;
            xcount <= '0;
            rowbuf <= '0;
        end else begin
            if (y_clr) begin
                ycount <= '0;
            end else if (y_inc) begin
                ycount <= ycount + 4'd1;
            end
            if (x_clr) begin
                xcount <= '0;
            end else if (x_inc) begin
                xcount <= xcount + 1'b1;
            end
            if (row_ld) begin
                rowbuf <= rom_bits;
            end
        end
    end

    // Pixel bit selection: mirrored rows walk the word up then back down.
    always_comb begin
`ifdef SPRITE_MIRROR_EN
        bit_idx = xcount[XW-1] ? ~xcount[IDX_W-1:0] : xcount[IDX_W-1:0];
`else
        bit_idx = ~xcount[IDX_W-1:0];
`endif
    end

    assign gfx         = (state == DRAW) && rowbuf[bit_idx];
    assign in_progress = (state != WAIT_VSTART);
    assign rom_addr    = ycount;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - self-checking bench for sprite_renderer (honours SPRITE_MIRROR_EN)
module tb_sprite_renderer;

`ifdef SPRITE_MIRROR_EN
    localparam int ROW_LEN = 16;
`else
    localparam int ROW_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       vstart;
    logic       load;
    logic       hstart;
    logic [3:0] rom_addr;
    logic [7:0] rom_bits;
    logic       gfx;
    logic       in_progress;

    logic [7:0] rom [16];
    int         checks = 0;
    int         errors = 0;

    sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .vstart      (vstart),
        .load        (load),
        .hstart      (hstart),
        .rom_addr    (rom_addr),
        .rom_bits    (rom_bits),
        .gfx         (gfx),
        .in_progress (in_progress)
    );

    always #5 clk = ~clk;

    assign rom_bits = rom[rom_addr];

    // Reference pixel rule for pixel k of a row word.
    function automatic logic ref_pix(input logic [7:0] row, input int k);
`ifdef SPRITE_MIRROR_EN
        if (k < 8) return row[k];
        return row[15 - k];
`else
        return row[7 - k];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scanline: stray hstart, load, stray load, hstart, then collect ROW_LEN pixels.
    task automatic do_line(input int y, input bit active, input int exp_addr, output logic [15:0] pat);
        pat = '0;
        hstart = 1'b1; step(); hstart = 1'b0;
        check("stray_hstart_gfx", gfx, 0);
        load = 1'b1; step(); load = 1'b0;
        check("setup_rom_addr", rom_addr, exp_addr);
        step(); step();
        load = 1'b1; step(); load = 1'b0;
        check("stray_load_gfx", gfx, 0);
        repeat ($urandom_range(0, 2)) step();
        hstart = 1'b1; step(); hstart = 1'b0;
        for (int k = 0; k < ROW_LEN; k++) begin
            check("draw_pixel", gfx, active ? ref_pix(rom[y], k) : 1'b0);
            check("draw_in_progress", in_progress, active);
            pat[k] = gfx;
            step();
        end
        check("after_line_gfx", gfx, 0);
    endtask

    initial begin
        logic [15:0] pat;
        reset  = 1'b0;
        vstart = 1'b0;
        load   = 1'b0;
        hstart = 1'b0;
        rom[0] = 8'h00;
        rom[1] = 8'b0000_1100;
        rom[2] = 8'b1100_0000;
        for (int i = 3; i < 16; i++) rom[i] = 8'($urandom);

        #3;
        check("reset_gfx", gfx, 0);
        check("reset_in_progress", in_progress, 0);
        check("reset_rom_addr", rom_addr, 0);
        step(); step();
        reset = 1'b1;
        step();
        check("idle_in_progress", in_progress, 0);

        // Full frame of 16 lines.
        vstart = 1'b1; step(); vstart = 1'b0;
        check("vstart_in_progress", in_progress, 1);
        check("vstart_rom_addr", rom_addr, 0);
        for (int y = 0; y < 16; y++) begin
            do_line(y, 1'b1, y, pat);
            if (y == 0) check("row0_blank", pat, 0);
`ifdef SPRITE_MIRROR_EN
            if (y == 1) check("row1_mirror_pattern", pat, 16'b0011000000001100);
`else
            if (y == 2) check("row2_plain_pattern", pat[7:0], 8'b00000011);
`endif
        end
        check("frame_end_in_progress", in_progress, 0);
        check("frame_end_rom_addr", rom_addr, 15);
        do_line(0, 1'b0, 15, pat);
        check("line17_in_progress", in_progress, 0);

        // vstart during DRAW of row 9 restarts the frame.
        vstart = 1'b1; step(); vstart = 1'b0;
        for (int y = 0; y < 9; y++) do_line(y, 1'b1, y, pat);
        load = 1'b1; step(); load = 1'b0;
        step(); step();
        hstart = 1'b1; step(); hstart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("row9_pixel", gfx, ref_pix(rom[9], k));
            step();
        end
        vstart = 1'b1; step(); vstart = 1'b0;
        check("resync_rom_addr", rom_addr, 0);
        check("resync_gfx", gfx, 0);
        check("resync_in_progress", in_progress, 1);
        do_line(0, 1'b1, 0, pat);
        do_line(1, 1'b1, 1, pat);

        // Reset during DRAW of row 5.
        vstart = 1'b1; step(); vstart = 1'b0;
        for (int y = 0; y < 5; y++) do_line(y, 1'b1, y, pat);
        load = 1'b1; step(); load = 1'b0;
        step(); step();
        hstart = 1'b1; step(); hstart = 1'b0;
        check("row5_in_progress", in_progress, 1);
        step();
        #2 reset = 1'b0;
        #1;
        check("midreset_gfx", gfx, 0);
        check("midreset_in_progress", in_progress, 0);
        check("midreset_rom_addr", rom_addr, 0);
        step();
        reset = 1'b1;
        do_line(5, 1'b0, 0, pat);
        check("post_reset_in_progress", in_progress, 0);
        vstart = 1'b1; step(); vstart = 1'b0;
        do_line(0, 1'b1, 0, pat);
        do_line(1, 1'b1, 1, pat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
